// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a dual-port RAM: independent round-robin
// arbitration of the write port and the registered-read port.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 32,
  localparam int unsigned RW        = $clog2(ROWS),
  localparam int unsigned CW        = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [RW-1:0]         a_req_row,
  input  logic [CW-1:0]         a_req_col,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,

  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [RW-1:0]         b_req_row,
  input  logic [CW-1:0]         b_req_col,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,

  output logic                  ram_we,
  output logic [RW-1:0]         ram_w_row,
  output logic [CW-1:0]         ram_w_col,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [RW-1:0]         ram_r_row,
  output logic [CW-1:0]         ram_r_col,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {PICK_A = 1'b0, PICK_B = 1'b1} pick_e;

  pick_e wr_ptr_q, wr_ptr_d;
  pick_e rd_ptr_q, rd_ptr_d;
  pick_e rd_owner_q, rd_owner_d;
  logic  rd_valid_q, rd_valid_d;

  logic a_wr, b_wr, a_rd, b_rd;
  logic gnt_a_wr, gnt_b_wr, gnt_a_rd, gnt_b_rd;

  // Contention is only resolved within a class; reset masks every request.
  always_comb begin
    a_wr = a_req_valid &&  a_req_we && !rst;
    b_wr = b_req_valid &&  b_req_we && !rst;
    a_rd = a_req_valid && !a_req_we && !rst;
    b_rd = b_req_valid && !b_req_we && !rst;

    gnt_a_wr = a_wr && (!b_wr || (wr_ptr_q == PICK_A));
    gnt_b_wr = b_wr && (!a_wr || (wr_ptr_q == PICK_B));
    gnt_a_rd = a_rd && (!b_rd || (rd_ptr_q == PICK_A));
    gnt_b_rd = b_rd && (!a_rd || (rd_ptr_q == PICK_B));

    a_req_ready = gnt_a_wr || gnt_a_rd;
    b_req_ready = gnt_b_wr || gnt_b_rd;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_w_row = '0;
    ram_w_col = '0;
    ram_din   = '0;
    if (gnt_a_wr) begin
      ram_we    = 1'b1;
      ram_w_row = a_req_row;
      ram_w_col = a_req_col;
      ram_din   = a_req_wdata;
    end else if (gnt_b_wr) begin
      ram_we    = 1'b1;
      ram_w_row = b_req_row;
      ram_w_col = b_req_col;
      ram_din   = b_req_wdata;
    end
  end

  always_comb begin
    ram_r_row = '0;
    ram_r_col = '0;
    if (gnt_a_rd) begin
      ram_r_row = a_req_row;
      ram_r_col = a_req_col;
    end else if (gnt_b_rd) begin
      ram_r_row = b_req_row;
      ram_r_col = b_req_col;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (gnt_a_wr)      wr_ptr_d = PICK_B;
    else if (gnt_b_wr) wr_ptr_d = PICK_A;

    rd_ptr_d = rd_ptr_q;
    if (gnt_a_rd)      rd_ptr_d = PICK_B;
    else if (gnt_b_rd) rd_ptr_d = PICK_A;

    rd_valid_d = gnt_a_rd || gnt_b_rd;
    rd_owner_d = gnt_b_rd ? PICK_B : PICK_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PICK_A;
      rd_ptr_q   <= PICK_A;
      rd_owner_q <= PICK_A;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_owner_q <= rd_owner_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // A read accepted just before reset must not surface while rst is high.
  always_comb begin
    a_rsp_valid = rd_valid_q && (rd_owner_q == PICK_A) && !rst;
    b_rsp_valid = rd_valid_q && (rd_owner_q == PICK_B) && !rst;
    a_rsp_data  = ram_dout;
    b_rsp_data  = ram_dout;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_clr;

  logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [1:0] a_req_row;
  logic [4:0] a_req_col;
  logic [7:0] a_req_wdata, a_rsp_data;
  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [1:0] b_req_row;
  logic [4:0] b_req_col;
  logic [7:0] b_req_wdata, b_rsp_data;
  logic       ram_we;
  logic [1:0] ram_w_row, ram_r_row;
  logic [4:0] ram_w_col, ram_r_col;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [4][32];

  int errors   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(8), .ROWS(4), .COLS(32)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_row(a_req_row), .a_req_col(a_req_col), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_row(b_req_row), .b_req_col(b_req_col), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .ram_we(ram_we), .ram_w_row(ram_w_row), .ram_w_col(ram_w_col),
    .ram_din(ram_din), .ram_r_row(ram_r_row), .ram_r_col(ram_r_col),
    .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 32; c++)
          mem[r][c] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_we) mem[ram_w_row][ram_w_col] <= ram_din;
      ram_dout <= mem[ram_r_row][ram_r_col];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic we, input logic [1:0] row,
                       input logic [4:0] col, input logic [7:0] wd);
    a_req_valid = v; a_req_we = we; a_req_row = row; a_req_col = col; a_req_wdata = wd;
  endtask

  task automatic drv_b(input logic v, input logic we, input logic [1:0] row,
                       input logic [4:0] col, input logic [7:0] wd);
    b_req_valid = v; b_req_we = we; b_req_row = row; b_req_col = col; b_req_wdata = wd;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ram_clr = 1'b1;
    drv_a(1'b1, 1'b1, 2'd1, 5'd1, 8'hFF);
    drv_b(1'b1, 1'b0, 2'd2, 5'd2, 8'hEE);
    next_cycle(); next_cycle();
    #1;
    check("rst_a_ready", a_req_ready, 0);
    check("rst_b_ready", b_req_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    check("rst_addr", {ram_w_row, ram_w_col, ram_din, ram_r_row, ram_r_col}, 0);
    next_cycle();
    rst = 1'b0; ram_clr = 1'b0;
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("post_rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);

    // Single writer, then read back
    next_cycle();
    drv_a(1'b1, 1'b1, 2'd2, 5'd5, 8'h3C);
    #1;
    check("t1_a_ready", a_req_ready, 1);
    check("t1_b_ready", b_req_ready, 0);
    check("t1_wr", {ram_we, ram_w_row, ram_w_col, ram_din}, {1'b1, 2'd2, 5'd5, 8'h3C});
    next_cycle();
    drv_a(1'b1, 1'b0, 2'd2, 5'd5, 8'h00);
    #1;
    check("t1_rd_ready", a_req_ready, 1);
    check("t1_rd_addr", {ram_r_row, ram_r_col}, {2'd2, 5'd5});
    check("t1_we_off", {ram_we, ram_w_row, ram_w_col, ram_din}, 0);
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t1_rsp", {a_rsp_valid, b_rsp_valid, a_rsp_data}, {1'b1, 1'b0, 8'h3C});
    next_cycle();
    #1;
    check("t1_rsp_gone", {a_rsp_valid, b_rsp_valid}, 0);

    // Write contention from a freshly reset pointer
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drv_a(1'b1, 1'b1, 2'd0, 5'd3, 8'h11);
    drv_b(1'b1, 1'b1, 2'd0, 5'd3, 8'h22);
    #1;
    check("t2_c1", {a_req_ready, b_req_ready, ram_din}, {1'b1, 1'b0, 8'h11});
    next_cycle();
    drv_a(1'b1, 1'b1, 2'd0, 5'd3, 8'h33);
    #1;
    check("t2_c2", {a_req_ready, b_req_ready, ram_din}, {1'b0, 1'b1, 8'h22});
    next_cycle();
    drv_b(1'b1, 1'b1, 2'd0, 5'd3, 8'h44);
    #1;
    check("t2_c3", {a_req_ready, b_req_ready, ram_din}, {1'b1, 1'b0, 8'h33});
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t2_c4", {a_req_ready, b_req_ready, ram_din}, {1'b0, 1'b1, 8'h44});
    next_cycle();
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_a(1'b1, 1'b0, 2'd0, 5'd3, 8'h00);
    #1;
    check("t2_rd_ready", a_req_ready, 1);
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t2_final", {a_rsp_valid, a_rsp_data}, {1'b1, 8'h44});

    // Parallel write and read of the same cell
    next_cycle();
    drv_a(1'b1, 1'b1, 2'd1, 5'd7, 8'h55);
    drv_b(1'b1, 1'b0, 2'd1, 5'd7, 8'h00);
    #1;
    check("t3_both_ready", {a_req_ready, b_req_ready}, 2'b11);
    check("t3_ports", {ram_we, ram_w_row, ram_w_col, ram_r_row, ram_r_col},
          {1'b1, 2'd1, 5'd7, 2'd1, 5'd7});
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t3_old", {a_rsp_valid, b_rsp_valid, b_rsp_data}, {1'b0, 1'b1, 8'h00});
    check("t3_b_ready2", b_req_ready, 1);
    next_cycle();
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t3_new", {b_rsp_valid, b_rsp_data}, {1'b1, 8'h55});

    // Streaming reads from both requesters
    next_cycle();
    drv_a(1'b1, 1'b0, 2'd0, 5'd3, 8'h00);
    drv_b(1'b1, 1'b0, 2'd1, 5'd7, 8'h00);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("t4_gnt%0d", i), {a_req_ready, b_req_ready},
            (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0)
        check($sformatf("t4_rsp%0d", i), {a_rsp_valid, b_rsp_valid, a_rsp_data},
              (i % 2 == 1) ? {2'b10, 8'h44} : {2'b01, 8'h55});
      next_cycle();
    end
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t4_last", {a_rsp_valid, b_rsp_valid, b_rsp_data}, {2'b01, 8'h55});

    // Reset with a read in flight
    next_cycle();
    drv_a(1'b1, 1'b0, 2'd2, 5'd5, 8'h00);
    #1;
    check("t5_accept", a_req_ready, 1);
    next_cycle();
    rst = 1'b1;
    drv_b(1'b1, 1'b1, 2'd3, 5'd3, 8'h99);
    #1;
    check("t5_rsp_in_rst", {a_rsp_valid, b_rsp_valid}, 0);
    check("t5_ready_in_rst", {a_req_ready, b_req_ready}, 0);
    check("t5_ports_in_rst", {ram_we, ram_w_row, ram_w_col, ram_din, ram_r_row, ram_r_col}, 0);
    next_cycle();
    rst = 1'b0;
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t5_rsp_after", {a_rsp_valid, b_rsp_valid}, 0);
    next_cycle();
    drv_a(1'b1, 1'b1, 2'd3, 5'd0, 8'h01);
    drv_b(1'b1, 1'b1, 2'd3, 5'd1, 8'h02);
    #1;
    check("t5_wr_ptr", {a_req_ready, b_req_ready}, 2'b10);
    next_cycle();
    drv_a(1'b1, 1'b0, 2'd0, 5'd3, 8'h00);
    drv_b(1'b1, 1'b0, 2'd1, 5'd7, 8'h00);
    #1;
    check("t5_rd_ptr", {a_req_ready, b_req_ready}, 2'b10);

    // Address corners
    next_cycle();
    drv_a(1'b1, 1'b1, 2'd0, 5'd0, 8'hA5);
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t6_wr00", {ram_we, ram_w_row, ram_w_col, ram_din}, {1'b1, 2'd0, 5'd0, 8'hA5});
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_b(1'b1, 1'b1, 2'd3, 5'd31, 8'h5A);
    #1;
    check("t6_wr331", {ram_we, ram_w_row, ram_w_col, ram_din}, {1'b1, 2'd3, 5'd31, 8'h5A});
    next_cycle();
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_a(1'b1, 1'b0, 2'd3, 5'd31, 8'h00);
    #1;
    check("t6_rd331", {a_req_ready, ram_r_row, ram_r_col}, {1'b1, 2'd3, 5'd31});
    next_cycle();
    drv_a(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    drv_b(1'b1, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t6_rsp331", {a_rsp_valid, a_rsp_data}, {1'b1, 8'h5A});
    next_cycle();
    drv_b(1'b0, 1'b0, 2'd0, 5'd0, 8'h00);
    #1;
    check("t6_rsp00", {b_rsp_valid, b_rsp_data}, {1'b1, 8'hA5});

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the dual-port 2D RAM (separate write and read ports, registered read, 1-cycle read latency) between two requesters, A and B.
- The write port and the read port are arbitrated independently, each with its own round-robin pointer, so one write and one read can issue in the same cycle.
- Read data returns to the issuing requester with a response valid flag.
- The block sits between the compute clients and the RAM instance; the RAM's own reset is driven separately.

Parameters:
- DATA_WIDTH, 8, width of each RAM element.
- ROWS, 4, RAM row count; RW = $clog2(ROWS).
- COLS, 32, RAM column count; CW = $clog2(COLS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- a_req_valid  in  1  requester A command valid.
- a_req_ready  out  1  A command accepted this cycle.
- a_req_we  in  1  A command type: 1 = write, 0 = read.
- a_req_row  in  RW  A row address.
- a_req_col  in  CW  A column address.
- a_req_wdata  in  DATA_WIDTH  A write data.
- a_rsp_valid  out  1  A read data valid.
- a_rsp_data  out  DATA_WIDTH  A read data.
- b_req_valid, b_req_ready, b_req_we, b_req_row, b_req_col, b_req_wdata, b_rsp_valid, b_rsp_data: same as the A ports, for requester B.
- ram_we  out  1  RAM write enable.
- ram_w_row  out  RW  RAM write row.
- ram_w_col  out  CW  RAM write column.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_r_row  out  RW  RAM read row.
- ram_r_col  out  CW  RAM read column.
- ram_dout  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- **Handshake:**
  - A command is accepted in a cycle where req_valid && req_ready.
  - req_ready is combinational from the current valids and the pointers.
  - The requester holds valid, we, row, col and wdata stable until accepted.
  - ready never depends on the command fields of the other class.
- **Classes:**
  - Write class: the valid requesters with we = 1.
  - Read class: the valid requesters with we = 0.
  - Each class grants at most one requester per cycle.
  - A and B can be granted in the same cycle only if they are in different classes.
- **Arbitration, per class:**
  - Exactly one contender: it is granted.
  - Both contend: the requester named by that class's pointer (wr_ptr or rd_ptr; 0 = A, 1 = B) is granted.
  - After any grant in a class, that pointer moves to the requester not granted. No grant leaves the pointer unchanged.
  - Worst-case wait under contention is 1 cycle.
- **Write path:**
  - In the accept cycle, ram_we = 1 and ram_w_row/ram_w_col/ram_din come from the granted requester (combinational).
  - Otherwise ram_we = 0 and the write address/data are driven to 0.
- **Read path:**
  - In the accept cycle, ram_r_row/ram_r_col come from the granted requester; otherwise they are driven to 0.
  - A registered owner flag plus a valid flag capture the grant.
  - In the next cycle, the owner's rsp_valid = 1 and the other's rsp_valid = 0.
  - rsp_data = ram_dout for both requesters (passthrough); it is meaningful only when rsp_valid = 1.
  - Latency: accept at cycle N, response at cycle N+1.
  - Back-to-back reads are accepted every cycle, giving a response every cycle.
- **Same-address write and read in the same cycle:** the read returns the pre-write value, per the RAM's registered read. Read-after-write one or more cycles later returns the new value.
- **Two writes to the same address:** they are serialised by arbitration. The later-granted write wins.
- **Reset (rst = 1, synchronous):**
  - While rst is high, both req_ready are forced to 0 and ram_we = 0.
  - On the clock edge with rst high: wr_ptr = 0, rd_ptr = 0, in-flight read dropped.
  - In the cycle after that edge, a_rsp_valid = b_rsp_valid = 0, even if a read was accepted in the cycle before reset.
  - RAM contents are not touched by this block.
- **Outputs during and immediately after reset:** all ready = 0, rsp_valid = 0, ram_we = 0, RAM addresses/data = 0.
- No internal buffering: a command is never accepted without being issued to the RAM in the same cycle.

Test Plan:
1. **Single writer:** A write row 2, col 5, 0x3C, with B idle → a_req_ready = 1 and ram_we = 1 at (2,5,0x3C) the same cycle. A later A read of (2,5) → a_rsp_valid = 1 and a_rsp_data = 0x3C one cycle after accept; b_rsp_valid stays 0.
2. **Write contention:** A and B both hold writes for 4 cycles after reset → grants A, B (B then idle); re-issue both → pointer now A, so A granted then B. Final RAM value at a shared address equals the later grant's data.
3. **Parallel classes:** A writes (1,7)=0x55 while B reads (1,7) in the same cycle, with the old value 0x00 → both ready = 1; next cycle b_rsp_data = 0x00. A second B read → 0x55.
4. **Streaming reads:** A and B both stream reads for 8 cycles → alternating A/B grants, one rsp_valid per cycle to the correct owner with matching data, never both rsp_valid high.
5. **Reset mid-read:** A read accepted in cycle N, rst high in cycle N+1 → a_rsp_valid = 0 in N+1 and N+2, all ready = 0 while rst is high, pointers back to A.
6. **Address boundaries:** writes/reads to (0,0) and (ROWS-1,COLS-1) = (3,31) pass through unmodified with correct data.
